// File: rtl/vpu_pkg.sv
// Shared types and routing constants for the VPU sequencer.
// Pathway encodings follow the vpu_data_pathway select of the VPU.
package vpu_pkg;

    typedef enum logic [1:0] {
        FWD     = 2'd0,
        TRANS   = 2'd1,
        BWD     = 2'd2,
        ILLEGAL = 2'd3
    } vpu_mode_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ARM  = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } vpu_seq_state_t;

    localparam logic [3:0] PATH_NONE  = 4'b0000;
    localparam logic [3:0] PATH_FWD   = 4'b1100;
    localparam logic [3:0] PATH_TRANS = 4'b1111;
    localparam logic [3:0] PATH_BWD   = 4'b0001;

    function automatic logic [3:0] path_of(vpu_mode_t m);
        case (m)
            FWD:     path_of = PATH_FWD;
            TRANS:   path_of = PATH_TRANS;
            BWD:     path_of = PATH_BWD;
            default: path_of = PATH_NONE;
        endcase
    endfunction

endpackage

// File: rtl/vpu_lane_counter.sv
// One VPU lane: row/column wrap counters on the SA input valids and a
// saturating count of VPU output valids, compared against rows*cols.
module vpu_lane_counter #(
    parameter int ROW_W = 4,
    parameter int COL_W = 4,
    parameter int TOT_W = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic             in_valid,
    input  logic             out_valid,
    input  logic [ROW_W:0]   rows,
    input  logic [COL_W:0]   cols,
    input  logic [TOT_W-1:0] total,
    output logic [ROW_W-1:0] row,
    output logic [COL_W-1:0] col,
    output logic             full_next
);

    logic [ROW_W-1:0] row_q, row_d;
    logic [COL_W-1:0] col_q, col_d;
    logic [TOT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        row_d = row_q;
        col_d = col_q;
        cnt_d = cnt_q;
        if (clr) begin
            row_d = '0;
            col_d = '0;
            cnt_d = '0;
        end else if (en) begin
            if (in_valid) begin
                if ({1'b0, row_q} == rows - 1'b1) begin
                    row_d = '0;
                    col_d = ({1'b0, col_q} == cols - 1'b1) ? '0 : col_q + 1'b1;
                end else begin
                    row_d = row_q + 1'b1;
                end
            end
            if (out_valid && (cnt_q != total)) begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Completion is judged on the post-increment count so the last valid
    // of a lane counts in the same cycle it arrives.
    assign full_next = (cnt_d == total);
    assign row       = row_q;
    assign col       = col_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            row_q <= '0;
            col_q <= '0;
            cnt_q <= '0;
        end else begin
            row_q <= row_d;
            col_q <= col_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/vpu_sequencer.sv
// Per-command controller for the two-lane VPU: routes the pathway, walks UB
// indices per lane and counts output valids. Watchdog under VPU_SEQ_TIMEOUT_EN.
//
// state | meaning
// IDLE  | ready for a command; illegal commands pulse cmd_err here
// ARM   | pathway driven, counters cleared, rows*cols computed
// RUN   | counting input/output valids until both lanes complete
// DONE  | one-cycle done pulse, pathway held
module vpu_sequencer
    import vpu_pkg::*;
#(
    parameter int MAX_B       = 16,
    parameter int MAX_D       = 16,
    parameter int ROW_W       = $clog2(MAX_B),
    parameter int COL_W       = $clog2(MAX_D),
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_mode,
    input  logic [ROW_W:0]   cmd_rows,
    input  logic [COL_W:0]   cmd_cols,
    output logic [3:0]       vpu_data_pathway,
    input  logic             sa_valid_1,
    input  logic             sa_valid_2,
    input  logic             vpu_valid_out_1,
    input  logic             vpu_valid_out_2,
    output logic [ROW_W-1:0] ub_row_1,
    output logic [ROW_W-1:0] ub_row_2,
    output logic [COL_W-1:0] ub_col_1,
    output logic [COL_W-1:0] ub_col_2,
    output logic             busy,
    output logic             done,
    output logic             cmd_err
);

    localparam int TOT_W = ROW_W + COL_W + 2;
    localparam logic [ROW_W:0] MAX_B_V = (ROW_W + 1)'(MAX_B);
    localparam logic [COL_W:0] MAX_D_V = (COL_W + 1)'(MAX_D);

    vpu_seq_state_t   state_q, state_d;
    vpu_mode_t        mode_q, mode_d;
    logic [ROW_W:0]   rows_q, rows_d;
    logic [COL_W:0]   cols_q, cols_d;
    logic [TOT_W-1:0] total_q, total_d;
    logic             cmd_err_q, cmd_err_d;
    logic             full_1, full_2;
    logic             cmd_illegal;

`ifdef VPU_SEQ_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
    logic [WD_W-1:0] wd_q, wd_d;
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYC == 0);
`endif

    assign cmd_illegal = (cmd_mode == 2'd3) || (cmd_rows == '0) || (cmd_rows > MAX_B_V)
                       || (cmd_cols == '0) || (cmd_cols > MAX_D_V);

    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        rows_d    = rows_q;
        cols_d    = cols_q;
        total_d   = total_q;
        cmd_err_d = 1'b0;
`ifdef VPU_SEQ_TIMEOUT_EN
        wd_d      = wd_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    if (cmd_illegal) begin
                        cmd_err_d = 1'b1;
                    end else begin
                        mode_d  = vpu_mode_t'(cmd_mode);
                        rows_d  = cmd_rows;
                        cols_d  = cmd_cols;
                        state_d = S_ARM;
                    end
                end
            end
            S_ARM: begin
                total_d = TOT_W'(rows_q) * TOT_W'(cols_q);
                state_d = S_RUN;
`ifdef VPU_SEQ_TIMEOUT_EN
                wd_d    = '0;
`endif
            end
            S_RUN: begin
`ifdef VPU_SEQ_TIMEOUT_EN
                wd_d = (vpu_valid_out_1 || vpu_valid_out_2) ? '0 : wd_q + 1'b1;
`endif
                if (full_1 && full_2) begin
                    state_d = S_DONE;
                end
`ifdef VPU_SEQ_TIMEOUT_EN
                else if (wd_d == WD_W'(TIMEOUT_CYC)) begin
                    state_d   = S_DONE;
                    cmd_err_d = 1'b1;
                end
`endif
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            mode_q    <= FWD;
            rows_q    <= '0;
            cols_q    <= '0;
            total_q   <= '0;
            cmd_err_q <= 1'b0;
`ifdef VPU_SEQ_TIMEOUT_EN
            wd_q      <= '0;
`endif
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            rows_q    <= rows_d;
            cols_q    <= cols_d;
            total_q   <= total_d;
            cmd_err_q <= cmd_err_d;
`ifdef VPU_SEQ_TIMEOUT_EN
            wd_q      <= wd_d;
`endif
        end
    end

    assign cmd_ready        = (state_q == S_IDLE);
    assign busy             = (state_q != S_IDLE);
    assign done             = (state_q == S_DONE);
    assign cmd_err          = cmd_err_q;
    assign vpu_data_pathway = (state_q == S_IDLE) ? PATH_NONE : path_of(mode_q);

    vpu_lane_counter #(.ROW_W(ROW_W), .COL_W(COL_W), .TOT_W(TOT_W)) u_lane_1 (
        .clk       (clk),
        .rst       (rst),
        .clr       (state_q == S_ARM),
        .en        (state_q == S_RUN),
        .in_valid  (sa_valid_1),
        .out_valid (vpu_valid_out_1),
        .rows      (rows_q),
        .cols      (cols_q),
        .total     (total_q),
        .row       (ub_row_1),
        .col       (ub_col_1),
        .full_next (full_1)
    );

    vpu_lane_counter #(.ROW_W(ROW_W), .COL_W(COL_W), .TOT_W(TOT_W)) u_lane_2 (
        .clk       (clk),
        .rst       (rst),
        .clr       (state_q == S_ARM),
        .en        (state_q == S_RUN),
        .in_valid  (sa_valid_2),
        .out_valid (vpu_valid_out_2),
        .rows      (rows_q),
        .cols      (cols_q),
        .total     (total_q),
        .row       (ub_row_2),
        .col       (ub_col_2),
        .full_next (full_2)
    );

endmodule

// File: tb/tb_vpu_sequencer.sv
// Bench for vpu_sequencer: directed scenarios plus random commands, every
// cycle checked against a count-based reference model.
module tb_vpu_sequencer;

`ifdef VPU_SEQ_TIMEOUT_EN
    localparam int TO    = 16;
    localparam bit TO_EN = 1'b1;
`else
    localparam int TO    = 1024;
    localparam bit TO_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_mode;
    logic [4:0] cmd_rows;
    logic [4:0] cmd_cols;
    logic [3:0] vpu_data_pathway;
    logic       sa_valid_1, sa_valid_2;
    logic       vpu_valid_out_1, vpu_valid_out_2;
    logic [3:0] ub_row_1, ub_row_2;
    logic [3:0] ub_col_1, ub_col_2;
    logic       busy, done, cmd_err;

    int n_total = 0;
    int n_bad   = 0;

    // reference model: phase 0 idle, 1 arm, 2 run, 3 done
    int m_phase, m_mode, m_rows, m_cols, m_tot, m_wd;
    int m_in[2], m_out[2], m_row[2], m_col[2];
    bit m_err;

    vpu_sequencer #(.TIMEOUT_CYC(TO)) dut (
        .clk              (clk),
        .rst              (rst),
        .cmd_valid        (cmd_valid),
        .cmd_ready        (cmd_ready),
        .cmd_mode         (cmd_mode),
        .cmd_rows         (cmd_rows),
        .cmd_cols         (cmd_cols),
        .vpu_data_pathway (vpu_data_pathway),
        .sa_valid_1       (sa_valid_1),
        .sa_valid_2       (sa_valid_2),
        .vpu_valid_out_1  (vpu_valid_out_1),
        .vpu_valid_out_2  (vpu_valid_out_2),
        .ub_row_1         (ub_row_1),
        .ub_row_2         (ub_row_2),
        .ub_col_1         (ub_col_1),
        .ub_col_2         (ub_col_2),
        .busy             (busy),
        .done             (done),
        .cmd_err          (cmd_err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] exp_path(int md);
        case (md)
            0:       return 32'hC;
            1:       return 32'hF;
            2:       return 32'h1;
            default: return 32'h0;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = 0; m_mode = 0; m_rows = 1; m_cols = 1; m_tot = 0; m_wd = 0; m_err = 0;
        for (int l = 0; l < 2; l++) begin
            m_in[l] = 0; m_out[l] = 0; m_row[l] = 0; m_col[l] = 0;
        end
    endtask

    task automatic lane_step(input int l, input logic v_in, input logic v_out);
        if (v_in) begin
            m_in[l]++;
            m_row[l] = m_in[l] % m_rows;
            m_col[l] = (m_in[l] / m_rows) % m_cols;
        end
        if (v_out && m_out[l] < m_tot) m_out[l]++;
    endtask

    task automatic model_step();
        if (rst) begin
            model_reset();
        end else begin
            m_err = 0;
            case (m_phase)
                0: if (cmd_valid) begin
                    if (cmd_mode != 2'd3 && cmd_rows >= 1 && cmd_rows <= 16 &&
                        cmd_cols >= 1 && cmd_cols <= 16) begin
                        m_mode = int'(cmd_mode); m_rows = int'(cmd_rows);
                        m_cols = int'(cmd_cols); m_phase = 1;
                    end else begin
                        m_err = 1;
                    end
                end
                1: begin
                    m_tot = m_rows * m_cols; m_wd = 0; m_phase = 2;
                    for (int l = 0; l < 2; l++) begin
                        m_in[l] = 0; m_out[l] = 0; m_row[l] = 0; m_col[l] = 0;
                    end
                end
                2: begin
                    lane_step(0, sa_valid_1, vpu_valid_out_1);
                    lane_step(1, sa_valid_2, vpu_valid_out_2);
                    m_wd = (vpu_valid_out_1 || vpu_valid_out_2) ? 0 : m_wd + 1;
                    if (m_out[0] == m_tot && m_out[1] == m_tot) m_phase = 3;
                    else if (TO_EN && m_wd == TO) begin
                        m_phase = 3; m_err = 1;
                    end
                end
                default: m_phase = 0;
            endcase
        end
    endtask

    task automatic check_all();
        chk("cmd_ready", {31'b0, cmd_ready}, {31'b0, m_phase == 0});
        chk("busy", {31'b0, busy}, {31'b0, m_phase != 0});
        chk("done", {31'b0, done}, {31'b0, m_phase == 3});
        chk("cmd_err", {31'b0, cmd_err}, {31'b0, m_err});
        chk("pathway", {28'b0, vpu_data_pathway}, (m_phase == 0) ? 32'h0 : exp_path(m_mode));
        chk("ub_row_1", {28'b0, ub_row_1}, m_row[0]);
        chk("ub_col_1", {28'b0, ub_col_1}, m_col[0]);
        chk("ub_row_2", {28'b0, ub_row_2}, m_row[1]);
        chk("ub_col_2", {28'b0, ub_col_2}, m_col[1]);
    endtask

    task automatic cyc();
        @(negedge clk);
        check_all();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic setv(input bit a1, input bit a2, input bit o1, input bit o2);
        sa_valid_1 = a1; sa_valid_2 = a2; vpu_valid_out_1 = o1; vpu_valid_out_2 = o2;
    endtask

    task automatic issue(input int md, input int r, input int c);
        cmd_mode = 2'(md); cmd_rows = 5'(r); cmd_cols = 5'(c);
        cmd_valid = 1'b1;
        cyc();
        cmd_valid = 1'b0;
        cyc();
    endtask

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_mode = '0; cmd_rows = '0; cmd_cols = '0;
        setv(0, 0, 0, 0);
        @(posedge clk);
        model_reset();
        #1;
        cyc(); cyc();
        rst = 1'b0;

        // forward 4x2, aligned lanes, outputs two cycles behind inputs
        issue(0, 4, 2);
        for (int i = 0; i < 16; i++) begin
            setv(i < 8, i < 8, i >= 2 && i < 10, i >= 2 && i < 10);
            cyc();
        end
        setv(0, 0, 0, 0);

        // transition 2x1, lane 2 lagging by three cycles
        issue(1, 2, 1);
        for (int i = 0; i < 10; i++) begin
            setv(i < 2, i >= 3 && i < 5, i >= 1 && i < 3, i >= 4 && i < 6);
            cyc();
        end
        setv(0, 0, 0, 0);

        // illegal commands, with valids that must be ignored in idle
        setv(1, 1, 1, 1);
        issue(3, 4, 2);
        issue(0, 0, 2);
        issue(2, 17, 3);
        issue(1, 4, 0);
        issue(0, 4, 17);
        setv(0, 0, 0, 0);

        // cmd_valid held across a whole command: re-accepted back in idle
        cmd_mode = 2'd2; cmd_rows = 5'd1; cmd_cols = 5'd1; cmd_valid = 1'b1;
        setv(1, 1, 1, 1);
        for (int i = 0; i < 8; i++) cyc();
        cmd_valid = 1'b0;
        for (int i = 0; i < 3; i++) cyc();
        setv(0, 0, 0, 0);

        // reset after 3 of 8 valids, then a clean forward command
        issue(0, 4, 2);
        for (int i = 0; i < 3; i++) begin
            setv(1, 1, 1, 1);
            cyc();
        end
        setv(0, 0, 0, 0);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        cyc();
        issue(0, 4, 2);
        for (int i = 0; i < 12; i++) begin
            setv(i < 8, i < 8, i < 8, i < 8);
            cyc();
        end
        setv(0, 0, 0, 0);

`ifdef VPU_SEQ_TIMEOUT_EN
        issue(2, 2, 2);
        for (int i = 0; i < 22; i++) cyc();
`endif

        // random commands with random valid density
        for (int k = 0; k < 10; k++) begin
            int p;
            int budget;
            p = int'($urandom_range(30, 100));
            issue(int'($urandom_range(0, 3)), int'($urandom_range(0, 17)), int'($urandom_range(0, 4)));
            budget = 0;
            while (m_phase != 0 && budget < 1000) begin
                setv($urandom_range(0, 99) < p, $urandom_range(0, 99) < p,
                     $urandom_range(0, 99) < p, $urandom_range(0, 99) < p);
                cyc();
                budget++;
            end
            setv(0, 0, 0, 0);
            cyc();
            chk("rand_complete", {31'b0, busy}, 32'h0);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
